pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage 64-bit NPC core. Drives the valid/ena pair of every pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) plus pc_ena, and resolves four cases:
- load-use hazards
- multi-cycle memory stalls
- EX-stage redirects
- the system-instruction drain/halt sequence
Sits beside the decode stage; a pure control block with no datapath.

Parameters:
- DRAIN_CYCLES, 2, cycles from a sys instruction leaving EX until halt asserts (MEM+WB).
- MEM_TIMEOUT, 1024, max consecutive mem_busy cycles before a watchdog error; 0 disables the watchdog.
- CNT_W, 32, width of the watchdog counter and the perf counters.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1/rs2
- ex_load  in  1  instruction in EX is a load
- ex_rf_we  in  1  instruction in EX writes the register file
- ex_rf_waddr  in  5  destination register of the instruction in EX
- ex_sys  in  1  instruction in EX is ebreak/sys
- ex_redirect  in  1  EX resolved a taken branch/jump (PC redirect this cycle)
- mem_busy  in  1  LSU access not yet complete
- pc_ena  out  1  PC register update enable
- ifid_valid, ifid_ena  out  1 each
- idex_valid, idex_ena  out  1 each
- exmem_valid, exmem_ena  out  1 each
- memwb_valid, memwb_ena  out  1 each
- halt  out  1  core halted (sticky)
- wdog_err  out  1  memory watchdog fired (sticky)
- perf_stall  out  CNT_W  stall-cycle count
- perf_flush  out  CNT_W  flush-event count

Behaviour:
- Register encoding follows the pipeline-register contract:
  - valid=0 → bubble (clear) on the next edge.
  - valid=1, ena=1 → load.
  - valid=1, ena=0 → hold.
- FSM states: RUN, DRAIN, HALT.
  - Reset (rst=0, async) → RUN; drain counter and watchdog counter = 0; halt=0; wdog_err=0.
  - All *_valid and *_ena outputs are combinational. While rst=0 they read: valids 1, enas 0, pc_ena 0.
- RUN priority, highest first:
  1. mem_busy: freeze all. All enas=0, all valids=1, pc_ena=0. The watchdog counter increments. Any simultaneous redirect/hazard stays pending, because EX is held.
  2. ex_sys: idex_valid=0 and ifid_valid=0 (flush younger); pc_ena=0; exmem/memwb ena=1. Next state DRAIN with the counter loaded to DRAIN_CYCLES-1.
  3. ex_redirect: ifid_valid=0 and idex_valid=0; pc_ena=1 (PC takes the target); other stages ena=1. Counts one flush event.
  4. Load-use: ex_load & ex_rf_we & ex_rf_waddr!=0 & ((id_use_rs1 & id_rs1==ex_rf_waddr) | (id_use_rs2 & id_rs2==ex_rf_waddr)).
     - pc_ena=0, ifid_ena=0 (hold); idex_valid=0 (one bubble); exmem/memwb ena=1.
     - Exactly 1 stall cycle; the MEM→EX forward covers the rest.
  5. Otherwise all valid=1, ena=1, pc_ena=1.
- Watchdog:
  - The counter clears on any cycle with mem_busy=0.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT: wdog_err=1 and the next state is HALT.
- DRAIN:
  - pc_ena=0, ifid_valid=0, idex_valid=0; exmem/memwb ena=1, except they freeze while mem_busy (the counter holds too).
  - The counter decrements on non-busy cycles. At 0 → HALT.
- HALT:
  - All enas=0, pc_ena=0, valids=1; halt=1.
  - Exit only via reset.
- rx=x0 never raises a hazard. A redirect and a load-use in the same cycle → redirect wins, so no stall.

Optional Feature:
PIPE_CTRL_PERF_EN.
- Defined: perf_stall increments on every cycle where pc_ena=0 in RUN or DRAIN. perf_flush increments on each redirect or sys flush. Both wrap at 2^CNT_W and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package npc_pkg holds:
  - the state enum (RUN=2'd0, DRAIN=2'd1, HALT=2'd2)
  - REG_ZERO=5'd0
- One sub-module, pipe_hazard_det: purely combinational load-use comparator, output load_use.

Test Plan:
- Load-use: ex_load=1, ex_rf_waddr=5, id_rs1=5, id_use_rs1=1 → one cycle of pc_ena=0, ifid_ena=0, idex_valid=0; the next cycle returns to all-ena. With ex_rf_waddr=0 there is no stall.
- Redirect: ex_redirect=1 for 1 cycle → ifid_valid=0, idex_valid=0, pc_ena=1. perf_flush 0→1 when PERF_EN is defined.
- Mem stall: mem_busy=1 for 5 cycles with ex_redirect=1 held → all enas=0 for 5 cycles, then the redirect is applied on cycle 6.
- Sys: ex_sys=1 with DRAIN_CYCLES=2 → younger stages flushed and pc_ena=0. halt=1 exactly 2 cycles later and stays 1 for 100 cycles until rst=0.
- Watchdog: MEM_TIMEOUT=8, mem_busy stuck at 1 → wdog_err=1 and halt=1 after the 8th busy cycle. With MEM_TIMEOUT=0 they never fire.
- Async reset asserted mid-DRAIN, between clock edges → state RUN immediately, halt=0, counters 0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core pipeline control: FSM state codes, the
// zero-register index and the per-stage valid/enable bundle.
package npc_pkg;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_ena;
        logic ifid_valid;
        logic ifid_ena;
        logic idex_valid;
        logic idex_ena;
        logic exmem_valid;
        logic exmem_ena;
        logic memwb_valid;
        logic memwb_ena;
    } pipe_ctl_t;

    // Every register holds its contents and the PC stays put.
    function automatic pipe_ctl_t ctl_freeze();
        pipe_ctl_t c;
        c = '{pc_ena: 1'b0, ifid_valid: 1'b1, ifid_ena: 1'b0, idex_valid: 1'b1,
              idex_ena: 1'b0, exmem_valid: 1'b1, exmem_ena: 1'b0,
              memwb_valid: 1'b1, memwb_ena: 1'b0};
        return c;
    endfunction

    function automatic pipe_ctl_t ctl_run();
        pipe_ctl_t c;
        c = '1;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard comparator: flags an ID source that depends on a load
// currently in EX. Purely combinational.
module pipe_hazard_det
    import npc_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_load,
    input  logic       ex_rf_we,
    input  logic [4:0] ex_rf_waddr,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rf_waddr);
    assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rf_waddr);
    // x0 is hard-wired, so a load targeting it never creates a dependency.
    assign load_use = ex_load && ex_rf_we && (ex_rf_waddr != REG_ZERO) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 5-stage NPC core: stalls, flushes, drain/halt and
// memory watchdog. Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import npc_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 1024,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_load,
    input  logic             ex_rf_we,
    input  logic [4:0]       ex_rf_waddr,
    input  logic             ex_sys,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_ena,
    output logic             ifid_valid,
    output logic             ifid_ena,
    output logic             idex_valid,
    output logic             idex_ena,
    output logic             exmem_valid,
    output logic             exmem_ena,
    output logic             memwb_valid,
    output logic             memwb_ena,
    output logic             halt,
    output logic             wdog_err,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush
);

    localparam int unsigned      DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]    DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] WDOG_LIM   = CNT_W'(MEM_TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d, wdog_inc;
    logic             wdog_err_q, wdog_err_d;
    logic             wdog_hit;
    logic             load_use;
    pipe_ctl_t        ctl;

    pipe_hazard_det u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_load     (ex_load),
        .ex_rf_we    (ex_rf_we),
        .ex_rf_waddr (ex_rf_waddr),
        .load_use    (load_use)
    );

    // Saturate so a disabled watchdog never wraps back through the limit.
    assign wdog_inc = (&wdog_cnt_q) ? wdog_cnt_q : wdog_cnt_q + CNT_W'(1);
    assign wdog_hit = (MEM_TIMEOUT != 0) && (wdog_inc == WDOG_LIM);

    always_comb begin
        ctl        = ctl_run();
        state_d    = state_q;
        drain_d    = drain_q;
        wdog_err_d = wdog_err_q;
        wdog_cnt_d = mem_busy ? wdog_cnt_q : '0;

        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    ctl        = ctl_freeze();
                    wdog_cnt_d = wdog_inc;
                    if (wdog_hit) begin
                        wdog_err_d = 1'b1;
                        state_d    = HALT;
                    end
                end else if (ex_sys) begin
                    ctl.pc_ena     = 1'b0;
                    ctl.ifid_valid = 1'b0;
                    ctl.idex_valid = 1'b0;
                    state_d        = DRAIN;
                    drain_d        = DRAIN_LOAD;
                end else if (ex_redirect) begin
                    ctl.ifid_valid = 1'b0;
                    ctl.idex_valid = 1'b0;
                end else if (load_use) begin
                    ctl.pc_ena     = 1'b0;
                    ctl.ifid_ena   = 1'b0;
                    ctl.idex_valid = 1'b0;
                end
            end
            DRAIN: begin
                ctl.pc_ena     = 1'b0;
                ctl.ifid_valid = 1'b0;
                ctl.idex_valid = 1'b0;
                if (mem_busy) begin
                    ctl.exmem_ena = 1'b0;
                    ctl.memwb_ena = 1'b0;
                    wdog_cnt_d    = wdog_inc;
                    if (wdog_hit) begin
                        wdog_err_d = 1'b1;
                        state_d    = HALT;
                    end
                end else if (drain_q == '0) begin
                    state_d = HALT;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            HALT: begin
                ctl = ctl_freeze();
            end
            default: begin
                ctl     = ctl_freeze();
                state_d = RUN;
            end
        endcase

        if (!rst) begin
            ctl = ctl_freeze();
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            drain_q    <= '0;
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign pc_ena      = ctl.pc_ena;
    assign ifid_valid  = ctl.ifid_valid;
    assign ifid_ena    = ctl.ifid_ena;
    assign idex_valid  = ctl.idex_valid;
    assign idex_ena    = ctl.idex_ena;
    assign exmem_valid = ctl.exmem_valid;
    assign exmem_ena   = ctl.exmem_ena;
    assign memwb_valid = ctl.memwb_valid;
    assign memwb_ena   = ctl.memwb_ena;
    assign halt        = (state_q == HALT);
    assign wdog_err    = wdog_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall_q, perf_stall_d;
    logic [CNT_W-1:0] perf_flush_q, perf_flush_d;
    logic             stall_ev;
    logic             flush_ev;

    always_comb begin
        stall_ev     = rst && !ctl.pc_ena && ((state_q == RUN) || (state_q == DRAIN));
        flush_ev     = rst && (state_q == RUN) && !mem_busy && (ex_sys || ex_redirect);
        perf_stall_d = perf_stall_q + CNT_W'(stall_ev);
        perf_flush_d = perf_flush_q + CNT_W'(flush_ev);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule
